// File: rtl/serial_arith_pkg.sv
// Shared types and sizing helpers for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    // Sequencer states; encoding 2'b11 is illegal and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Bit-counter width for a WIDTH-bit serial operation (never below one bit).
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 3) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/fa_bit.sv
// Single-bit full adder built from two half-adder stages and an OR.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s1;
    logic c1;
    logic c2;

    // First half adder on the operand bits, second folds in the carry.
    always_comb begin
        s1 = a ^ b;
        c1 = a & b;
        s  = s1 ^ ci;
        c2 = s1 & ci;
        co = c1 | c2;
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: LSB-first through one full-adder cell,
// WIDTH RUN cycles per operation, results held until the next operation.
module serial_addsub
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned  CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             s_bit;
    logic             c_next;

    // The one shared adder cell works on the current LSBs and the carry.
    fa_bit u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (c),
        .s  (s_bit),
        .co (c_next)
    );

    // Sequencer, operand shifters, carry, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            c     <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1, so invert B and seed carry.
                        a_sh  <= a;
                        b_sh  <= sub ? ~b : b;
                        c     <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                        state <= RUN;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    sum  <= {s_bit, sum[WIDTH-1:1]};
                    a_sh <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                    c    <= c_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // MSB edge: carry-out and carry-in/out disagreement.
                        cout  <= c_next;
                        ovf   <= c ^ c_next;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub at WIDTH=8.
module tb_serial_addsub;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int total = 0;
    int bad   = 0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         sub;
        logic         cin;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the specified add/sub rules.
    task automatic model(input logic s, input logic ci, input logic [W-1:0] x,
                         input logic [W-1:0] y, output logic [W-1:0] r,
                         output logic co, output logic ov);
        int unsigned ux, uy, full;
        int sx, sy, sr;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            full = ux - uy;
            co   = (ux >= uy);
            sr   = sx - sy;
        end else begin
            full = ux + uy + int'(ci);
            co   = (full >= 256);
            sr   = sx + sy + int'(ci);
        end
        r  = full[W-1:0];
        ov = (sr > 127) || (sr < -128);
    endtask

    // Issue one operation from IDLE and collect the result at the done pulse.
    task automatic run_op(input logic s, input logic ci, input logic [W-1:0] x,
                          input logic [W-1:0] y, output logic [W-1:0] r,
                          output logic co, output logic ov, output int nbusy);
        int waitn;
        bit seen;
        waitn = 0;
        while (!ready && waitn < 20) begin
            @(negedge clk);
            waitn++;
        end
        sub   = s;
        cin   = ci;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        nbusy = 0;
        seen  = 1'b0;
        r = '0; co = 1'b0; ov = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                r = sum; co = cout; ov = ovf;
                break;
            end
            if (busy) nbusy++;
        end
        if (!seen) check("done_timeout", 64'd0, 64'd1);
        @(negedge clk);
        check("ready_after_done", 64'(ready), 64'd1);
        check("done_one_cycle", 64'(done), 64'd0);
    endtask

    initial begin
        logic [W-1:0] r, er;
        logic         co, ov, eco, eov;
        int           nb;
        int           ndone;
        int           idx;
        int           last_done;
        logic [W-1:0] pa[4];
        logic [W-1:0] pb[4];

        vecs[0] = '{sub:1'b0, cin:1'b0, a:8'h3C, b:8'h0F, sum:8'h4B, cout:1'b0, ovf:1'b0};
        vecs[1] = '{sub:1'b0, cin:1'b0, a:8'hFF, b:8'h01, sum:8'h00, cout:1'b1, ovf:1'b0};
        vecs[2] = '{sub:1'b0, cin:1'b1, a:8'hFF, b:8'h00, sum:8'h00, cout:1'b1, ovf:1'b0};
        vecs[3] = '{sub:1'b1, cin:1'b1, a:8'h05, b:8'h07, sum:8'hFE, cout:1'b0, ovf:1'b0};
        vecs[4] = '{sub:1'b1, cin:1'b0, a:8'h80, b:8'h01, sum:8'h7F, cout:1'b1, ovf:1'b1};
        vecs[5] = '{sub:1'b0, cin:1'b0, a:8'h7F, b:8'h01, sum:8'h80, cout:1'b0, ovf:1'b1};

        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        #12;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_done",  64'(done),  64'd0);
        check("rst_sum",   64'(sum),   64'd0);
        check("rst_cout",  64'(cout),  64'd0);
        check("rst_ovf",   64'(ovf),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].sub, vecs[i].cin, vecs[i].a, vecs[i].b, r, co, ov, nb);
            check($sformatf("vec%0d_busy_cycles", i), 64'(nb), 64'd8);
            check($sformatf("vec%0d_sum", i),  64'(r),  64'(vecs[i].sum));
            check($sformatf("vec%0d_cout", i), 64'(co), 64'(vecs[i].cout));
            check($sformatf("vec%0d_ovf", i),  64'(ov), 64'(vecs[i].ovf));
        end

        // Results are held through IDLE.
        repeat (3) @(negedge clk);
        check("hold_sum", 64'(sum), 64'h80);
        check("hold_ovf", 64'(ovf), 64'd1);

        // Start and operand changes during RUN are ignored.
        sub = 1'b0; cin = 1'b0; a = 8'h3C; b = 8'h0F; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i == 2) begin
                start = 1'b1; a = 8'h11; b = 8'h22;
            end else if (i == 3) begin
                start = 1'b0; a = 8'hA5; b = 8'h5A; sub = 1'b1;
            end
            if (done) begin
                ndone++;
                check("ignore_sum", 64'(sum), 64'h4B);
                check("ignore_cout", 64'(cout), 64'd0);
            end
        end
        check("ignore_done_count", 64'(ndone), 64'd1);

        // Asynchronous reset between edges mid-RUN.
        sub = 1'b0; a = 8'h3C; b = 8'h0F; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_ready", 64'(ready), 64'd1);
        check("arst_busy",  64'(busy),  64'd0);
        check("arst_done",  64'(done),  64'd0);
        check("arst_sum",   64'(sum),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(1'b1, 1'b0, 8'h40, 8'h10, r, co, ov, nb);
        check("post_rst_sum",  64'(r),  64'h30);
        check("post_rst_cout", 64'(co), 64'd1);

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            logic rs, rc;
            logic [W-1:0] ra, rb;
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            ra = W'($urandom);
            rb = W'($urandom);
            if (i < 4) begin
                ra = (i % 2 == 0) ? 8'h80 : 8'h7F;
                rb = (i < 2) ? 8'h80 : 8'hFF;
            end
            model(rs, rc, ra, rb, er, eco, eov);
            run_op(rs, rc, ra, rb, r, co, ov, nb);
            check($sformatf("rnd%0d_sum", i),  64'(r),  64'(er));
            check($sformatf("rnd%0d_cout", i), 64'(co), 64'(eco));
            check($sformatf("rnd%0d_ovf", i),  64'(ov), 64'(eov));
        end

        // Back-to-back with start held high: one result every 10 cycles.
        pa[0] = 8'h12; pb[0] = 8'h34;
        pa[1] = 8'hF0; pb[1] = 8'h20;
        pa[2] = 8'h7F; pb[2] = 8'h7F;
        pa[3] = 8'h01; pb[3] = 8'hFF;
        sub = 1'b0; cin = 1'b0;
        @(negedge clk);
        idx = 0; ndone = 0; last_done = -1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (done) begin
                if (ndone < 4) begin
                    model(1'b0, 1'b0, pa[ndone], pb[ndone], er, eco, eov);
                    check($sformatf("b2b%0d_sum", ndone),  64'(sum),  64'(er));
                    check($sformatf("b2b%0d_cout", ndone), 64'(cout), 64'(eco));
                    check($sformatf("b2b%0d_ovf", ndone),  64'(ovf),  64'(eov));
                end
                if (last_done >= 0)
                    check("b2b_period", 64'(cyc - last_done), 64'd10);
                last_done = cyc;
                ndone++;
            end
            if (ready) begin
                if (idx < 4) begin
                    a = pa[idx]; b = pb[idx]; start = 1'b1;
                    idx++;
                end else begin
                    start = 1'b0;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("b2b_done_count", 64'(ndone), 64'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parameterised bit-serial adder/subtractor, the sequential successor to the team's combinational half adder.
- Operands are captured on a start handshake and processed LSB-first, one bit per clock, through a single full-adder cell and a registered carry.
- Intended for area-constrained datapaths where WIDTH-cycle latency is acceptable.
- Result, carry-out and signed overflow are held stable until the next operation.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while ready=1.
- sub  input  1  0 = add (a+b+cin), 1 = subtract (a-b); sampled with start.
- cin  input  1  carry-in for add; ignored when sub=1.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- ready  output  1  high in IDLE; start accepted.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; sum/cout/ovf valid.
- sum  output  WIDTH  result.
- cout  output  1  final carry-out (for sub: 1 = no borrow).
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is asynchronous, active-high; takes effect immediately, independent of clk.
- Reset values: state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0, ovf=0, carry register=0, bit counter=0.
- FSM states IDLE, RUN, DONE.
- IDLE -> RUN: on an edge with start=1, the block captures:
  - a into shift register A.
  - b (or ~b when sub=1) into shift register B.
  - carry register = sub ? 1 : cin.
  - counter = 0.
  - sum/cout/ovf keep their previous values until overwritten by the new operation.
- Each RUN edge:
  - s = A[0]^B[0]^c.
  - c_next = majority(A[0],B[0],c).
  - sum shifts right with s inserted at MSB.
  - A and B shift right.
  - counter increments.
- Overflow capture: on the bit-(WIDTH-1) edge, ovf = c ^ c_next, i.e. carry into MSB XOR carry out of MSB.
- RUN -> DONE: on the edge that processes bit WIDTH-1 (counter==WIDTH-1). The same edge registers cout=c_next.
- DONE -> IDLE: unconditionally on the next edge.
- Outputs by state:
  - done=1 only in DONE.
  - busy=1 only in RUN.
  - ready=1 only in IDLE.
- Latency: start sampled at edge E0; done high in the cycle after edge E_WIDTH; ready again after E_(WIDTH+1). Throughput is one operation per WIDTH+2 cycles.
- Busy-time inputs: start in RUN or DONE is ignored; no queuing. Changes to a/b/sub/cin after capture have no effect.
- Output hold: sum/cout/ovf hold their last result through IDLE until the next operation's RUN edges overwrite them.
- Partial results: sum shifts during RUN, so intermediate values are not meaningful. Consumers sample only on done.
- Reset during RUN or DONE: the operation is abandoned, all outputs return to reset values, and done is not asserted.
- Counter width: $clog2(WIDTH). Comparisons are made against WIDTH-1 sized to the counter width.

Decomposition:
- Shared package serial_arith_pkg:
  - State enum {IDLE, RUN, DONE}, 2-bit encoding 00/01/10.
  - Encoding 11 is illegal; the FSM recovers to IDLE.
  - Localparam function for counter width.
- One sub-module, fa_bit: combinational full adder (a, b, ci -> s, co) built as two half-adder stages plus OR.
  - Instantiated once.
  - Reused by future serial multipliers.

Test Plan (WIDTH=8):
- Basic add with timing: a=0x3C, b=0x0F, sub=0, cin=0, start one cycle. Required response: busy for 8 cycles, then done pulse 1 cycle, sum=0x4B, cout=0, ovf=0, ready returns the following cycle.
- Unsigned wrap and carry-in:
  - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0.
  - a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
- Subtraction:
  - sub=1, a=0x05, b=0x07, cin=1 (ignored) -> sum=0xFE, cout=0 (borrow), ovf=0.
  - sub=1, a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
- Signed overflow: a=0x7F, b=0x01, sub=0 -> sum=0x80, ovf=1, cout=0.
- Ignored start and operand changes:
  - start pulsed in the 3rd RUN cycle with a=0x11, b=0x22 -> ignored; first result completes unchanged; exactly one done pulse.
  - a/b changed mid-RUN -> no effect.
- Async reset mid-operation and back-to-back:
  - Assert rst asynchronously mid-RUN, between edges -> ready=1, busy=0, done=0, sum=0 immediately.
  - After release, a new operation completes correctly.
  - Back-to-back starts held high continuously -> results every 10 cycles, correct for each operand pair.
